candy_mem_arb: RTL

Two-requester arbiter and sequencer for the single-ported `candy_sram` in the candy core. It shares the SRAM between instruction fetch (read-only) and the data path (load reads, writeback writes) using round-robin arbitration. It owns the SRAM `read_enable`/`write_enable` strobes and waits on `rdata_ready`, with a bounded timeout. Each requester gets a grant pulse and a completion pulse, so the core state machine no longer drives the SRAM directly.

---
 rtl/candy_mem_arb_pkg.sv | 22 ++
 rtl/candy_rr_pick2.sv | 41 ++++
 rtl/candy_mem_arb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/candy_mem_arb_pkg.sv
// candy_mem_arb_pkg
// Shared types and constants for the candy SRAM arbiter:
//   - arb_state_e : sequencer states (idle, read, write, response)
//   - owner_e     : which requester currently owns the SRAM
//   - ARB_TIMEOUT : default read-wait bound in cycles
package candy_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int ARB_TIMEOUT = 15;

endpackage

// File: rtl/candy_rr_pick2.sv
// candy_rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0] in  : bit 0 = fetch request, bit 1 = data request
//   last     in  : owner of the previous grant
//   valid    out : at least one request is pending
//   winner   out : selected owner (meaningful only when valid)
module candy_rr_pick2
    import candy_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic       valid,
    output owner_e     winner
);

    // Single requester wins outright; on a tie the requester that did not win last time goes.
    always_comb begin
        valid  = 1'b0;
        winner = OWN_FETCH;
        case (req)
            2'b01: begin
                valid  = 1'b1;
                winner = OWN_FETCH;
            end
            2'b10: begin
                valid  = 1'b1;
                winner = OWN_DATA;
            end
            2'b11: begin
                valid  = 1'b1;
                winner = (last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
            end
            default: begin
                valid  = 1'b0;
                winner = OWN_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/candy_mem_arb.sv
// candy_mem_arb
// Shares the single-ported candy SRAM between instruction fetch (read only)
// and the data path (reads and writes) with round-robin arbitration.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   f_req/f_addr                  : fetch read request (level) and address
//   f_gnt/f_valid/f_err/f_rdata   : fetch grant pulse, completion pulse, timeout flag, read data
//   d_req/d_we/d_addr/d_wdata     : data request (level), direction, address, write data
//   d_gnt/d_valid/d_err/d_rdata   : data grant pulse, completion pulse, timeout flag, read data
//   sram_re/sram_raddr            : SRAM read strobe and address
//   sram_rdata/sram_rdata_ready   : SRAM read data and its valid flag
//   sram_we/sram_waddr/sram_wdata : SRAM write strobe, address, data
//   busy                          : arbiter is not idle
// Every output is a register loaded from the value it must show in the state
// being entered, so outputs line up with the state cycle-for-cycle.
module candy_mem_arb
    import candy_mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic              f_err,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_rdata_ready,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              busy
);

    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);

    arb_state_e        state_r, next_state_s;
    owner_e            last_r, next_last_s;
    owner_e            own_r, next_own_s;
    logic [ADDR_W-1:0] addr_r, next_addr_s;
    logic [DATA_W-1:0] wdata_r, next_wdata_s;
    logic [TCNT_W-1:0] tcnt_r, next_tcnt_s;
    logic              win_valid_s;
    owner_e            win_s;
    logic              rd_done_s;
    logic              rd_err_s;

    candy_rr_pick2 u_pick (
        .req    ({d_req, f_req}),
        .last   (last_r),
        .valid  (win_valid_s),
        .winner (win_s)
    );

    // Next-state, capture and timeout-counter logic.
    always_comb begin
        next_state_s = state_r;
        next_last_s  = last_r;
        next_own_s   = own_r;
        next_addr_s  = addr_r;
        next_wdata_s = wdata_r;
        next_tcnt_s  = tcnt_r;
        rd_done_s    = 1'b0;
        rd_err_s     = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (win_valid_s) begin
                    next_last_s = win_s;
                    next_own_s  = win_s;
                    next_tcnt_s = '0;
                    if (win_s == OWN_DATA) begin
                        next_addr_s  = d_addr;
                        next_wdata_s = d_wdata;
                        next_state_s = d_we ? ARB_WR : ARB_RD;
                    end else begin
                        // Fetch is read-only; its write data is never used.
                        next_addr_s  = f_addr;
                        next_wdata_s = '0;
                        next_state_s = ARB_RD;
                    end
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_RD: begin
                if (sram_rdata_ready) begin
                    rd_done_s    = 1'b1;
                    next_state_s = ARB_RESP;
                end else if (tcnt_r == TCNT_MAX) begin
                    rd_done_s    = 1'b1;
                    rd_err_s     = 1'b1;
                    next_state_s = ARB_RESP;
                end else begin
                    next_tcnt_s  = tcnt_r + TCNT_W'(1);
                    next_state_s = ARB_RD;
                end
            end
            ARB_WR: begin
                next_state_s = ARB_IDLE;
            end
            ARB_RESP: begin
                next_state_s = ARB_IDLE;
            end
            default: begin
                next_state_s = ARB_IDLE;
            end
        endcase
    end

    // State, capture registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ARB_IDLE;
            last_r     <= OWN_DATA;
            own_r      <= OWN_FETCH;
            addr_r     <= '0;
            wdata_r    <= '0;
            tcnt_r     <= '0;
            f_gnt      <= 1'b0;
            f_valid    <= 1'b0;
            f_err      <= 1'b0;
            f_rdata    <= '0;
            d_gnt      <= 1'b0;
            d_valid    <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
            sram_re    <= 1'b0;
            sram_raddr <= '0;
            sram_we    <= 1'b0;
            sram_waddr <= '0;
            sram_wdata <= '0;
            busy       <= 1'b0;
        end else begin
            state_r <= next_state_s;
            last_r  <= next_last_s;
            own_r   <= next_own_s;
            addr_r  <= next_addr_s;
            wdata_r <= next_wdata_s;
            tcnt_r  <= next_tcnt_s;

            // Grants pulse only on the transition out of IDLE.
            f_gnt <= (state_r == ARB_IDLE) && (next_state_s == ARB_RD) && (next_own_s == OWN_FETCH);
            d_gnt <= (state_r == ARB_IDLE) && (next_state_s != ARB_IDLE) && (next_own_s == OWN_DATA);

            // Writes complete in their single WR cycle; reads complete in RESP.
            f_valid <= (next_state_s == ARB_RESP) && (next_own_s == OWN_FETCH);
            d_valid <= ((next_state_s == ARB_RESP) && (next_own_s == OWN_DATA)) || (next_state_s == ARB_WR);
            f_err   <= rd_err_s && (own_r == OWN_FETCH);
            d_err   <= rd_err_s && (own_r == OWN_DATA);

            // Read data is held until the owner's next read completion; a timeout returns zero.
            if (rd_done_s && (own_r == OWN_FETCH)) begin
                f_rdata <= rd_err_s ? '0 : sram_rdata;
            end else begin
                f_rdata <= f_rdata;
            end
            if (rd_done_s && (own_r == OWN_DATA)) begin
                d_rdata <= rd_err_s ? '0 : sram_rdata;
            end else begin
                d_rdata <= d_rdata;
            end

            sram_re    <= (next_state_s == ARB_RD);
            sram_raddr <= (next_state_s == ARB_RD) ? next_addr_s : '0;
            sram_we    <= (next_state_s == ARB_WR);
            sram_waddr <= (next_state_s == ARB_WR) ? next_addr_s : '0;
            sram_wdata <= (next_state_s == ARB_WR) ? next_wdata_s : '0;
            busy       <= (next_state_s != ARB_IDLE);
        end
    end

endmodule
